// File: rtl/max_issue.sv
`default_nettype none
// ============================================================================
// Module      : max_issue
// Description : In-order issue queue ahead of max_decode. MAX ops are issued as
//               a registered one-cycle pulse, gated by a destination scoreboard;
//               all other opcodes leave through a valid/ready aux port.
//               Optional counters are built when MAX_ISSUE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module max_issue #(
    parameter int          DEPTH   = 8,
    parameter logic [3:0]  MAX_OP  = 4'h3,
    parameter int          MAX_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_inst_i,
    output logic        max_en_o,
    output logic [11:0] max_inst_o,
    output logic        aux_valid_o,
    input  logic        aux_ready_i,
    output logic [15:0] aux_inst_o,
`ifdef MAX_ISSUE_STATS_EN
    output logic [15:0] stat_issued_o,
    output logic [15:0] stat_stall_o,
`endif
    output logic        busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [MAX_LAT-1:0] sb_v_q;
    logic [3:0]         sb_dst_q [MAX_LAT];

    logic        max_en_q;
    logic [11:0] max_inst_q;

    logic [15:0] head;
    logic        empty;
    logic        full;
    logic        head_is_max;
    logic        hazard;
    logic        push;
    logic        max_pop;
    logic        aux_pop;
    logic        pop;

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign head_is_max = !empty && (head[15:12] == MAX_OP);

    // A register is pending while any live scoreboard stage names it.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < MAX_LAT; i++) begin
            if (sb_v_q[i] && ((sb_dst_q[i] == head[11:8]) ||
                              (sb_dst_q[i] == head[7:4])  ||
                              (sb_dst_q[i] == head[3:0]))) begin
                hazard = 1'b1;
            end
        end
    end

    assign in_ready_o  = !full;
    assign push        = in_valid_i && !full && !flush_i;
    assign max_pop     = head_is_max && !hazard && !flush_i;
    // Valid is withdrawn during flush so an aux handshake never reports a
    // transfer that the flush is about to discard.
    assign aux_valid_o = !empty && !head_is_max && !flush_i;
    assign aux_inst_o  = head;
    assign aux_pop     = aux_valid_o && aux_ready_i;
    assign pop         = max_pop || aux_pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_inst_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            max_en_q   <= 1'b0;
            max_inst_q <= '0;
            sb_v_q     <= '0;
            for (int i = 0; i < MAX_LAT; i++) sb_dst_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            max_en_q <= max_pop;
            if (max_pop) max_inst_q <= head[11:0];
            for (int i = MAX_LAT - 1; i > 0; i--) begin
                sb_v_q[i]   <= sb_v_q[i-1];
                sb_dst_q[i] <= sb_dst_q[i-1];
            end
            sb_v_q[0]   <= max_pop;
            sb_dst_q[0] <= head[3:0];
        end
    end

    assign max_en_o   = max_en_q;
    assign max_inst_o = max_inst_q;
    assign busy_o     = !empty || (|sb_v_q);

`ifdef MAX_ISSUE_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (max_pop && (stat_issued_q != 16'hFFFF))
                stat_issued_q <= stat_issued_q + 16'd1;
            if (head_is_max && hazard && (stat_stall_q != 16'hFFFF))
                stat_stall_q <= stat_stall_q + 16'd1;
        end
    end

    assign stat_issued_o = stat_issued_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: doc/max_issue.md
Name: max_issue

Overview:
Issue stage directly upstream of max_decode in the CNN datapath. It buffers 16-bit instructions from fetch in an in-order queue and decodes the opcode. MAX instructions go to max_decode as a one-cycle en pulse with a 12-bit operand field {src1, src2, dst}. Other opcodes go out on a valid/ready aux port. A per-register scoreboard holds back MAX ops with RAW/WAW hazards against in-flight MAX results.

Parameters:
DEPTH, 8, instruction queue entries (power of 2, >=2)
MAX_OP, 4'h3, opcode value in inst[15:12] that selects MAX
MAX_LAT, 2, cycles a MAX result is in flight before its dst register is readable (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
flush  in  1  sync queue clear
in_valid  in  1  fetch offers in_inst
in_ready  out  1  queue can accept
in_inst  in  16  [15:12] opcode, [11:8] src1, [7:4] src2, [3:0] dst
max_en  out  1  one-cycle issue pulse to max_decode
max_inst  out  12  operand field for max_decode, valid when max_en=1
aux_valid  out  1  head is a non-MAX instruction
aux_ready  in  1  aux consumer accepts
aux_inst  out  16  full head instruction
busy  out  1  queue non-empty or any scoreboard entry live

Behaviour:
- Reset (async, rst_n=0): queue empty, pointers/count 0, scoreboard clear, max_en=0, max_inst=0, in_ready=1 after release, aux_valid=0, busy=0.
- Queue: circular, DEPTH entries. Push when in_valid && in_ready. in_ready = !full, driven from registered count. No write-through when full.
- Push and pop in the same cycle are legal and leave count unchanged. Pointers wrap modulo DEPTH.
- Strict in-order: only the head may leave. A stalled head blocks everything behind it.
- MAX head (opcode==MAX_OP) pops in cycle t when src1, src2 and dst are all not pending.
- On that pop, max_en=1 and max_inst=head[11:0] are registered and visible in cycle t+1 only. max_en is 0 otherwise. max_inst holds its last value.
- Non-MAX head: aux_valid=1 (combinational from head). aux_inst=head. Pops on aux_valid && aux_ready. aux_inst is don't-care when aux_valid=0.
- At most one pop per cycle.
- Scoreboard: shift line of MAX_LAT stages, each holding {valid, dst[3:0]}.
  - A MAX pop in cycle t loads stage0 at t+1. Entries shift one stage per cycle and drop after stage MAX_LAT-1.
  - A register is pending while any valid stage holds it, i.e. cycles t+1..t+MAX_LAT.
  - Result: a dependent MAX gets its max_en exactly MAX_LAT+1 cycles after the producer's max_en.
  - Non-MAX instructions never touch the scoreboard.
- Flush: at the next edge the queue empties (count=0, rd_ptr=wr_ptr), and no pop or push happens that cycle even if in_valid=1.
  - The scoreboard keeps draining and in-flight max_en still appears.
  - Flush while empty is a no-op.
- busy = (count!=0) || any scoreboard stage valid.
- rst_n asserted mid-operation: immediate clear of all state. A pending max_en pulse is squashed.

Optional Feature:
MAX_ISSUE_STATS_EN: when defined, adds outputs stat_issued[15:0] and stat_stall[15:0].
- stat_issued counts max_en pulses.
- stat_stall counts cycles the head is MAX but blocked by the scoreboard.
- Both saturate at 16'hFFFF, clear on reset, and are unaffected by flush.
When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single MAX: push 16'h3123 at cycle 0 into empty queue -> pop cycle 1, max_en=1 with max_inst=12'h123 in cycle 2 only; busy=0 at cycle 5 (MAX_LAT=2).
- RAW hazard: push 16'h3123 then 16'h3345 back-to-back -> first max_en at cycle c, second (12'h345) at c+3; stat_stall=2 with MAX_ISSUE_STATS_EN.
- Independent ops: push 16'h3123, 16'h3456, 16'h3789 -> max_en in three consecutive cycles with 12'h123, 12'h456, 12'h789.
- Aux path: push 16'h5ABC, aux_ready=0 for 4 cycles -> aux_valid=1, aux_inst=16'h5ABC held; the MAX pushed behind it does not issue; aux_ready=1 -> pop, MAX issues one cycle later.
- Full/wrap: aux_ready=0, push 10 non-MAX instrs -> in_ready=0 after 8 accepted, entries 9-10 held by fetch; drain 8 and push 8 more -> order preserved across pointer wrap.
- Flush/reset: flush with 5 queued entries -> count=0 next cycle, in-flight max_en still seen; rst_n=0 mid-pulse -> max_en=0 immediately, in_ready=1 after release.
